// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the restoring divider slice.
//   WIDTH     : operand/result width (only 32 is supported)
//   CNT_W     : iteration counter width
//   state_t   : IDLE / ITER / DONE
//   QUOT_DIV0 : quotient reported for a zero divisor
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] QUOT_DIV0 = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: one restoring-division step, purely combinational.
// Shifts the next dividend bit into the partial remainder, tries to subtract
// the divisor, and keeps the difference only if it did not go negative.
//   rem_in  in  WIDTH+1  current partial remainder
//   in_bit  in  1        dividend bit shifted in (MSB of dq)
//   dvs     in  WIDTH    captured divisor
//   rem_out out WIDTH+1  partial remainder after this step
//   qbit    out 1        quotient bit produced by this step
module div_trial_sub
    import div_pkg::*;
(
    input  logic [WIDTH:0]   rem_in,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    // The partial remainder is always below the divisor, so its top bit is
    // zero and this one-bit-wider subtract equals the 33-bit trial
    // {rem[31:0], bit} - {1'b0, dvs}; the extra bit is only the sign.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem_in, in_bit};
    assign trial   = shifted - {2'b00, dvs};
    assign qbit    = ~trial[WIDTH+1];
    assign rem_out = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/restoring_divider_32b.sv
// restoring_divider_32b: sequential 32-bit unsigned restoring divider,
// one quotient bit per clock (32 iterations, one division per 33 cycles).
//   clk          in   clock, rising edge
//   r            in   synchronous active-high reset
//   start        in   request, sampled in IDLE or DONE
//   dividend     in   32-bit numerator, captured on the accepting edge
//   divisor      in   32-bit denominator, captured on the accepting edge
//   busy         out  high while iterating
//   done         out  one-cycle strobe when results become valid
//   quotient     out  32-bit result, held until the next result
//   remainder    out  32-bit result, held until the next result
//   div_by_zero  out  high with done for a zero divisor, held with results
// Optional feature macro: DIV_ZERO_DETECT_EN (zero divisor finishes in one
// cycle and raises div_by_zero; otherwise div_by_zero is tied low).
module restoring_divider_32b
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   rem_next;
    logic             qbit;
    logic [WIDTH-1:0] dq_next;

    div_trial_sub u_trial (
        .rem_in  (rem),
        .in_bit  (dq[WIDTH-1]),
        .dvs     (dvs),
        .rem_out (rem_next),
        .qbit    (qbit)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign dq_next = {dq[WIDTH-2:0], qbit};

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q;
    // Set on a zero-divisor accept; the following DONE cycle publishes the
    // results so done appears one edge after acceptance.
    logic div0_pend;
    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all state advances
    // together on the edge; blocking assignments would let later statements
    // see half-updated values.
    always_ff @(posedge clk) begin
        if (r) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            rem       <= '0;
            dq        <= '0;
            dvs       <= '0;
            cnt       <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= 1'b0;
            div0_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (div0_pend) begin
                        // Result cycle of a zero-divisor request; start is
                        // not sampled until the next DONE cycle.
                        quotient  <= QUOT_DIV0;
                        remainder <= dq;
                        dz_q      <= 1'b1;
                        done      <= 1'b1;
                        div0_pend <= 1'b0;
                        state     <= DONE;
                    end else
`endif
                    if (start) begin
                        rem <= '0;
                        dq  <= dividend;
                        dvs <= divisor;
                        cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            div0_pend <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ITER;
                        end
`else
                        busy  <= 1'b1;
                        state <= ITER;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                ITER: begin
                    rem <= rem_next;
                    dq  <= dq_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        quotient  <= dq_next;
                        remainder <= rem_next[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                        dz_q      <= 1'b0;
`endif
                        state     <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_32b.sv
// tb_restoring_divider_32b: directed self-checking bench for
// restoring_divider_32b. Expectations follow DIV_ZERO_DETECT_EN when defined.
module tb_restoring_divider_32b;

    logic        clk;
    logic        r;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    restoring_divider_32b dut (
        .clk         (clk),
        .r           (r),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Called #1 after an accepting edge. Waits for done (bounded), checks
    // latency, busy duration, results and the one-cycle done pulse. Returns
    // #1 after the edge following done. With disturb set, start is re-pulsed
    // and the operands are changed while iterating.
    task automatic wait_result(input string tag, input logic [31:0] exp_q,
                               input logic [31:0] exp_r, input int exp_lat,
                               input int exp_busy, input logic exp_dz,
                               input bit disturb);
        int lat = 0;
        int busy_cnt = 0;
        int overlap = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (disturb && lat == 5) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd3;
            end
            if (disturb && lat == 8) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (done && busy) overlap++;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_cnt, exp_busy);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
        @(posedge clk); #1;
        if (done && busy) overlap++;
        check({tag, " done_drop"}, {31'd0, done}, 32'd0);
        check({tag, " done_busy_overlap"}, overlap, 0);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r);
        accept(a, b);
        wait_result(tag, exp_q, exp_r, 32, 32, 1'b0, 1'b0);
    endtask

    initial begin
        r        = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        r = 1'b0;

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_div("msb/max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0);

        // Zero divisor.
        accept(32'd5, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
        wait_result("5/0", 32'hFFFF_FFFF, 32'd5, 1, 0, 1'b1, 1'b0);
`else
        wait_result("5/0", 32'hFFFF_FFFF, 32'd5, 32, 32, 1'b0, 1'b0);
`endif

        // Known non-zero results before the abort, so the reset is visible.
        run_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1);
        accept(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        r = 1'b1;
        @(posedge clk); #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        @(negedge clk);
        r = 1'b0;
        run_div("9/2", 32'd9, 32'd2, 32'd4, 32'd1);

        // Start re-pulsed and operands changed mid-iteration.
        accept(32'd100, 32'd7);
        wait_result("ignore", 32'd14, 32'd2, 32, 32, 1'b0, 1'b1);

        // Start held through DONE: back-to-back operations.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        wait_result("b2b first", 32'd14, 32'd2, 32, 32, 1'b0, 1'b0);
        check("b2b restart busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_result("b2b second", 32'd333, 32'd1, 32, 32, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
